i2c_slave: RTL and testbench

- I2C target (responder) for the codebase's I2C master; attaches to the same SDA/SCL pair.
- Oversamples SCL/SDA on clk_i and detects START/STOP.
- Matches its own 7-bit address, then stores up to 4 written bytes or returns up to 4 preloaded bytes.
- The CPU reaches it through the same word-addressed peripheral bus as the other protocol blocks.

---
 rtl/i2c_slave.sv | 257 +++++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C target with 4-byte RX/TX buffers behind a word-addressed register interface.
// Optional general-call (address 8'h00) support is enabled by defining I2C_SLAVE_GCALL_EN.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         NBYTES     = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        write_i,
  input  logic [3:0]  data_be_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR     = 3'd1;
  localparam logic [2:0] ADDR_ACK = 3'd2;
  localparam logic [2:0] RX       = 3'd3;
  localparam logic [2:0] RX_ACK   = 3'd4;
  localparam logic [2:0] TX       = 3'd5;
  localparam logic [2:0] TX_ACK   = 3'd6;
  localparam logic [2:0] IGNORE   = 3'd7;

  localparam logic [2:0] LAST_IDX = 3'(NBYTES);

  logic [1:0]  scl_sync, sda_sync;
  logic        scl_d, sda_d;
  logic        scl, sda;
  logic        scl_rise, scl_fall, start_det, stop_det;

  logic [2:0]  state;
  logic [2:0]  bit_cnt;
  logic [2:0]  byte_idx;
  logic [2:0]  nxt_idx;
  logic [7:0]  shreg;
  logic        byte_done;
  logic        addressed;
  logic        is_read;

  logic [31:0] rxd, txd;
  logic [6:0]  cfg_addr;
  logic        cfg_en;
  logic [2:0]  rx_cnt;
  logic        wr_done, rd_done, nack_ovf, gcall;

  logic [7:0]  cur_tx, nxt_tx;
  logic        addr_hit, gcall_hit;
  logic [2:0]  reg_sel;
  logic        unused_addr;

  function automatic logic [7:0] tx_sel(input logic [2:0] idx, input logic [31:0] t);
    case (idx)
      3'd0:    tx_sel = t[7:0];
      3'd1:    tx_sel = t[15:8];
      3'd2:    tx_sel = t[23:16];
      3'd3:    tx_sel = t[31:24];
      default: tx_sel = 8'hFF;
    endcase
  endfunction

  // Two synchroniser flops plus one history flop per line for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign scl       = scl_sync[1];
  assign sda       = sda_sync[1];
  assign scl_rise  = scl & ~scl_d;
  assign scl_fall  = ~scl & scl_d;
  assign start_det = scl & scl_d & sda_d & ~sda;
  assign stop_det  = scl & scl_d & ~sda_d & sda;

  assign reg_sel     = addr_i[4:2];
  assign unused_addr = ^addr_i[1:0];

  assign nxt_idx  = (byte_idx >= LAST_IDX) ? byte_idx : byte_idx + 3'd1;
  assign cur_tx   = tx_sel(byte_idx, txd);
  assign nxt_tx   = tx_sel(nxt_idx, txd);
  assign addr_hit = cfg_en && (shreg[7:1] == cfg_addr);
`ifdef I2C_SLAVE_GCALL_EN
  assign gcall_hit = cfg_en && (shreg == 8'h00);
`else
  assign gcall_hit = 1'b0;
`endif

  // CPU writes come first so that a hardware status set later in the block wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      bit_cnt   <= 3'd7;
      byte_idx  <= 3'd0;
      shreg     <= 8'h00;
      byte_done <= 1'b0;
      addressed <= 1'b0;
      is_read   <= 1'b0;
      sda_oe_o  <= 1'b0;
      rxd       <= 32'h0;
      txd       <= 32'h0;
      cfg_addr  <= SLAVE_ADDR;
      cfg_en    <= 1'b1;
      rx_cnt    <= 3'd0;
      wr_done   <= 1'b0;
      rd_done   <= 1'b0;
      nack_ovf  <= 1'b0;
      gcall     <= 1'b0;
    end else begin
      if (write_i) begin
        case (reg_sel)
          3'd1: begin
            for (int b = 0; b < 4; b++)
              if (data_be_i[b]) txd[b*8 +: 8] <= wdata_i[b*8 +: 8];
          end
          3'd2: begin
            if (data_be_i[1]) begin
              if (wdata_i[8])  wr_done  <= 1'b0;
              if (wdata_i[9])  rd_done  <= 1'b0;
              if (wdata_i[10]) nack_ovf <= 1'b0;
              if (wdata_i[11]) gcall    <= 1'b0;
            end
          end
          3'd3: begin
            if (data_be_i[0]) cfg_addr <= wdata_i[6:0];
            if (data_be_i[1]) cfg_en   <= wdata_i[8];
          end
          default: ;
        endcase
      end

      if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= 3'd7;
        byte_done <= 1'b0;
        sda_oe_o  <= 1'b0;
      end else if (stop_det) begin
        state     <= IDLE;
        byte_done <= 1'b0;
        sda_oe_o  <= 1'b0;
        addressed <= 1'b0;
        if (addressed) begin
          if (is_read) rd_done <= 1'b1;
          else         wr_done <= 1'b1;
        end
      end else begin
        case (state)
          ADDR, RX: begin
            if (scl_rise) begin
              shreg <= {shreg[6:0], sda};
              if (bit_cnt == 3'd0) byte_done <= 1'b1;
              else                 bit_cnt   <= bit_cnt - 3'd1;
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              bit_cnt   <= 3'd7;
              if (state == ADDR) begin
                byte_idx <= 3'd0;
                if (addr_hit || gcall_hit) begin
                  state     <= ADDR_ACK;
                  sda_oe_o  <= 1'b1;
                  addressed <= 1'b1;
                  is_read   <= shreg[0];
                  if (!shreg[0]) rx_cnt <= 3'd0;
                  if (gcall_hit) gcall <= 1'b1;
                end else begin
                  state <= IGNORE;
                end
              end else if (byte_idx < LAST_IDX) begin
                rxd[{byte_idx[1:0], 3'b000} +: 8] <= shreg;
                rx_cnt   <= rx_cnt + 3'd1;
                state    <= RX_ACK;
                sda_oe_o <= 1'b1;
              end else begin
                nack_ovf <= 1'b1;
                sda_oe_o <= 1'b0;
                state    <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (is_read) begin
                state    <= TX;
                sda_oe_o <= ~cur_tx[7];
              end else begin
                state    <= RX;
                sda_oe_o <= 1'b0;
              end
            end
          end
          RX_ACK: begin
            if (scl_fall) begin
              sda_oe_o <= 1'b0;
              byte_idx <= nxt_idx;
              state    <= RX;
            end
          end
          TX: begin
            if (scl_rise) begin
              if (bit_cnt == 3'd0) byte_done <= 1'b1;
              else                 bit_cnt   <= bit_cnt - 3'd1;
            end else if (scl_fall) begin
              if (byte_done) begin
                byte_done <= 1'b0;
                sda_oe_o  <= 1'b0;
                state     <= TX_ACK;
              end else begin
                sda_oe_o <= ~cur_tx[bit_cnt];
              end
            end
          end
          // Master's acknowledge is captured in shreg[0] on the ninth rising edge.
          TX_ACK: begin
            if (scl_rise) begin
              shreg     <= {shreg[6:0], sda};
              byte_done <= 1'b1;
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              bit_cnt   <= 3'd7;
              if (shreg[0]) begin
                state <= IGNORE;
              end else begin
                byte_idx <= nxt_idx;
                sda_oe_o <= ~nxt_tx[7];
                state    <= TX;
              end
            end
          end
          default: sda_oe_o <= 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    rdata_o = 32'h0;
    case (reg_sel)
      3'd0: rdata_o = rxd;
      3'd1: rdata_o = txd;
      3'd2: rdata_o = {20'h0, gcall, nack_ovf, rd_done, wr_done, 5'h0, rx_cnt};
      3'd3: rdata_o = {23'h0, cfg_en, 1'b0, cfg_addr};
      default: rdata_o = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: an open-drain bus model with a bit-banged master
// and CPU register accesses, checked with immediate assertions.
module tb_i2c_slave;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        write_i;
  logic [3:0]  data_be_i;
  logic [4:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        scl_m, sda_m;
  logic        sda_oe_o;
  logic        sda_line;

  int total = 0;
  int bad   = 0;

  logic        ack;
  logic [7:0]  rbyte;

  assign sda_line = sda_m & ~sda_oe_o;

  i2c_slave dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .write_i   (write_i),
    .data_be_i (data_be_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .rdata_o   (rdata_o),
    .scl_i     (scl_m),
    .sda_i     (sda_line),
    .sda_oe_o  (sda_oe_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    addr_i    = a;
    wdata_i   = d;
    data_be_i = be;
    write_i   = 1'b1;
    @(negedge clk_i);
    write_i   = 1'b0;
    data_be_i = 4'h0;
  endtask

  task automatic check_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    addr_i = a;
    #1;
    check_output(tag, rdata_o, exp);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; wait_clks(4);
    scl_m = 1'b1; wait_clks(8);
    sda_m = 1'b0; wait_clks(8);
    scl_m = 1'b0; wait_clks(4);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; wait_clks(4);
    scl_m = 1'b1; wait_clks(8);
    sda_m = 1'b1; wait_clks(8);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_clks(4);
      scl_m = 1'b1; wait_clks(8);
      scl_m = 1'b0; wait_clks(4);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack_o);
    send_bits(b);
    sda_m = 1'b1; wait_clks(4);
    scl_m = 1'b1; wait_clks(4);
    ack_o = sda_line;
    wait_clks(4);
    scl_m = 1'b0; wait_clks(4);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] b);
    sda_m = 1'b1;
    b = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      wait_clks(8);
      scl_m = 1'b1; wait_clks(4);
      b[i] = sda_line;
      wait_clks(4);
      scl_m = 1'b0;
    end
    wait_clks(4);
    sda_m = ack_bit; wait_clks(4);
    scl_m = 1'b1; wait_clks(8);
    scl_m = 1'b0; wait_clks(4);
    sda_m = 1'b1;
  endtask

  task automatic apply_stimulus_write(input logic [7:0] b, input logic exp_ack, input string tag);
    write_byte(b, ack);
    check_output(tag, {31'h0, ack}, {31'h0, exp_ack});
  endtask

  initial begin
    rst_ni    = 1'b1;
    write_i   = 1'b0;
    data_be_i = 4'h0;
    addr_i    = 5'd0;
    wdata_i   = 32'h0;
    scl_m     = 1'b1;
    sda_m     = 1'b1;

    // Reset state
    wait_clks(2);
    rst_ni = 1'b0;
    wait_clks(4);
    check_output("rst_sda_oe", {31'h0, sda_oe_o}, 32'h0);
    rst_ni = 1'b1;
    wait_clks(4);
    check_reg("rst_cfg", 5'd12, 32'h0000_0142);
    check_reg("rst_sts", 5'd8,  32'h0000_0000);
    check_reg("rst_rxd", 5'd0,  32'h0000_0000);
    check_reg("rst_txd", 5'd4,  32'h0000_0000);

    // Two-byte write
    i2c_start;
    apply_stimulus_write(8'h84, 1'b0, "wr_addr_ack");
    apply_stimulus_write(8'hA5, 1'b0, "wr_b0_ack");
    apply_stimulus_write(8'h3C, 1'b0, "wr_b1_ack");
    i2c_stop;
    check_reg("wr_rxd", 5'd0, 32'h0000_3CA5);
    check_reg("wr_sts", 5'd8, 32'h0000_0102);
    bus_write(5'd8, 32'h0000_0100, 4'b0010);
    check_reg("wr_sts_clr", 5'd8, 32'h0000_0002);

    // Five-byte read, last one beyond the buffer
    bus_write(5'd4, 32'hDDCC_BBAA, 4'b1111);
    check_reg("txd", 5'd4, 32'hDDCC_BBAA);
    i2c_start;
    apply_stimulus_write(8'h85, 1'b0, "rd_addr_ack");
    read_byte(1'b0, rbyte); check_output("rd_b0", {24'h0, rbyte}, 32'h0000_00AA);
    read_byte(1'b0, rbyte); check_output("rd_b1", {24'h0, rbyte}, 32'h0000_00BB);
    read_byte(1'b0, rbyte); check_output("rd_b2", {24'h0, rbyte}, 32'h0000_00CC);
    read_byte(1'b0, rbyte); check_output("rd_b3", {24'h0, rbyte}, 32'h0000_00DD);
    read_byte(1'b1, rbyte); check_output("rd_b4", {24'h0, rbyte}, 32'h0000_00FF);
    i2c_stop;
    check_reg("rd_sts", 5'd8, 32'h0000_0202);
    bus_write(5'd8, 32'h0000_0200, 4'b0010);
    check_reg("rd_sts_clr", 5'd8, 32'h0000_0002);

    // Six-byte write overflows the buffer
    i2c_start;
    apply_stimulus_write(8'h84, 1'b0, "ov_addr_ack");
    apply_stimulus_write(8'h11, 1'b0, "ov_b0_ack");
    apply_stimulus_write(8'h22, 1'b0, "ov_b1_ack");
    apply_stimulus_write(8'h33, 1'b0, "ov_b2_ack");
    apply_stimulus_write(8'h44, 1'b0, "ov_b3_ack");
    apply_stimulus_write(8'h55, 1'b1, "ov_b4_nack");
    apply_stimulus_write(8'h66, 1'b1, "ov_b5_nack");
    i2c_stop;
    check_reg("ov_rxd", 5'd0, 32'h4433_2211);
    check_reg("ov_sts", 5'd8, 32'h0000_0504);
    bus_write(5'd8, 32'h0000_0500, 4'b0010);
    check_reg("ov_sts_clr", 5'd8, 32'h0000_0004);

    // Foreign address, then repeated START to ours
    i2c_start;
    apply_stimulus_write(8'h90, 1'b1, "foreign_nack");
    check_output("foreign_oe", {31'h0, sda_oe_o}, 32'h0);
    check_reg("foreign_sts", 5'd8, 32'h0000_0004);
    i2c_start;
    apply_stimulus_write(8'h84, 1'b0, "rs_addr_ack");
    apply_stimulus_write(8'h5A, 1'b0, "rs_b0_ack");
    i2c_stop;
    check_reg("rs_rxd", 5'd0, 32'h4433_225A);
    check_reg("rs_sts", 5'd8, 32'h0000_0101);
    bus_write(5'd8, 32'h0000_0100, 4'b0010);

    // Disabled target, then a changed own address via byte enables
    bus_write(5'd12, 32'h0000_0000, 4'b0010);
    check_reg("cfg_dis", 5'd12, 32'h0000_0042);
    i2c_start;
    apply_stimulus_write(8'h84, 1'b1, "dis_nack");
    i2c_stop;
    check_reg("dis_sts", 5'd8, 32'h0000_0001);
    bus_write(5'd12, 32'hFFFF_0155, 4'b0011);
    check_reg("cfg_55", 5'd12, 32'h0000_0155);
    i2c_start;
    apply_stimulus_write(8'h84, 1'b1, "old_addr_nack");
    i2c_start;
    apply_stimulus_write(8'hAA, 1'b0, "new_addr_ack");
    i2c_stop;
    check_reg("new_addr_sts", 5'd8, 32'h0000_0100);
    check_reg("unmapped_16", 5'd16, 32'h0);
    check_reg("unmapped_28", 5'd28, 32'h0);
    bus_write(5'd12, 32'h0000_FF42, 4'b0001);
    check_reg("cfg_restore", 5'd12, 32'h0000_0142);

    // Reset while the address ACK is being driven
    i2c_start;
    send_bits(8'h84);
    sda_m = 1'b1;
    wait_clks(4);
    check_output("ack_oe_before_rst", {31'h0, sda_oe_o}, 32'h1);
    rst_ni = 1'b0;
    #1;
    check_output("ack_oe_async_rst", {31'h0, sda_oe_o}, 32'h0);
    wait_clks(3);
    rst_ni = 1'b1;
    wait_clks(4);
    apply_stimulus_write(8'h84, 1'b1, "no_start_nack");
    i2c_stop;
    check_reg("post_rst_sts", 5'd8, 32'h0000_0000);
    check_reg("post_rst_txd", 5'd4, 32'h0000_0000);
    i2c_start;
    apply_stimulus_write(8'h84, 1'b0, "recover_ack");
    apply_stimulus_write(8'h77, 1'b0, "recover_b0_ack");
    i2c_stop;
    check_reg("recover_rxd", 5'd0, 32'h0000_0077);
    bus_write(5'd8, 32'h0000_0100, 4'b0010);
    check_reg("recover_sts", 5'd8, 32'h0000_0001);

    // General call
    i2c_start;
`ifdef I2C_SLAVE_GCALL_EN
    apply_stimulus_write(8'h00, 1'b0, "gcall_ack");
    apply_stimulus_write(8'h11, 1'b0, "gcall_b0_ack");
    i2c_stop;
    check_reg("gcall_rxd", 5'd0, 32'h0000_0011);
    check_reg("gcall_sts", 5'd8, 32'h0000_0901);
    bus_write(5'd8, 32'h0000_0F00, 4'b0010);
    check_reg("gcall_sts_clr", 5'd8, 32'h0000_0001);
`else
    apply_stimulus_write(8'h00, 1'b1, "gcall_nack");
    i2c_stop;
    check_reg("gcall_sts", 5'd8, 32'h0000_0001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
